// File: rtl/mod_counter_pkg.sv
// rtl/mod_counter_pkg.sv - shared constants for the modulo up/down counter
// Purpose: direction encodings and default parameter values used by
//          mod_counter and counter_prescaler.
// Ports:   none (package).
package mod_counter_pkg;

  localparam logic DIR_UP = 1'b1;
  localparam logic DIR_DN = 1'b0;

  localparam int DEF_WIDTH    = 8;
  localparam int DEF_MAX_VAL  = 255;
  localparam int DEF_PRESCALE = 1;

endpackage

// File: rtl/counter_prescaler.sv
// rtl/counter_prescaler.sv - enable prescaler producing one step per PRESCALE enabled cycles
// Purpose: counts enabled cycles 0..PRESCALE-1 and asserts step (combinationally)
//          on the enabled cycle at PRESCALE-1, then returns to 0. en=0 freezes it.
// Ports:
//   clk      in  clock, rising edge
//   rst      in  asynchronous active-low reset
//   en       in  count enable
//   sync_clr in  synchronous clear of the prescaler phase
//   step     out step strobe for the counter
module counter_prescaler
  import mod_counter_pkg::*;
#(
  parameter int PRESCALE = DEF_PRESCALE
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic sync_clr,
  output logic step
);

  generate
    if (PRESCALE <= 1) begin : g_bypass
      // No phase to track: every enabled cycle is a step.
      logic unused_ports;
      assign unused_ports = &{1'b0, clk, rst, sync_clr};
      assign step = en;
    end else begin : g_div
      localparam int CW = $clog2(PRESCALE);
      localparam logic [CW-1:0] LAST = CW'(PRESCALE - 1);

      logic [CW-1:0] cnt_q, cnt_d;

      always_comb begin
        cnt_d = cnt_q;
        step  = 1'b0;
        if (sync_clr) begin
          cnt_d = '0;
        end else if (en) begin
          if (cnt_q == LAST) begin
            cnt_d = '0;
            step  = 1'b1;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
      end

      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          cnt_q <= '0;
        end else begin
          cnt_q <= cnt_d;
        end
      end
    end
  endgenerate

endmodule

// File: rtl/mod_counter.sv
// rtl/mod_counter.sv - parametrised modulo up/down counter with prescaler, load, clear, tc and sticky ovf
// Purpose: counts 0..MAX_VAL up or down, one step per PRESCALE enabled cycles.
//          Priority per edge: clr > load > step. Wrapping pulses tc for one cycle
//          and sets the sticky ovf flag (cleared by clr, load or reset).
// Configuration: define MOD_COUNTER_SAT_EN for saturating mode (hold at the
//          bound, set ovf, never pulse tc); undefined gives wrap-around mode.
// Ports:
//   clk       in  clock, rising edge
//   rst       in  asynchronous active-low reset
//   en        in  count enable (through prescaler)
//   up_dn     in  1 = up, 0 = down
//   clr       in  synchronous clear
//   load      in  synchronous parallel load
//   load_val  in  load value, clamped to MAX_VAL
//   out       out registered count
//   tc        out registered terminal-count pulse
//   ovf       out registered sticky overflow/underflow flag
module mod_counter
  import mod_counter_pkg::*;
#(
  parameter int WIDTH    = DEF_WIDTH,
  parameter int MAX_VAL  = DEF_MAX_VAL,
  parameter int PRESCALE = DEF_PRESCALE
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             up_dn,
  input  logic             clr,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] out,
  output logic             tc,
  output logic             ovf
);

  localparam logic [WIDTH-1:0] MAX = WIDTH'(MAX_VAL);

  logic [WIDTH-1:0] out_q, out_d;
  logic             tc_q, tc_d;
  logic             ovf_q, ovf_d;
  logic             step;

  counter_prescaler #(
    .PRESCALE(PRESCALE)
  ) u_prescaler (
    .clk     (clk),
    .rst     (rst),
    .en      (en),
    .sync_clr(clr | load),
    .step    (step)
  );

  always_comb begin
    out_d = out_q;
    tc_d  = 1'b0;
    ovf_d = ovf_q;
    if (clr) begin
      out_d = '0;
      ovf_d = 1'b0;
    end else if (load) begin
      out_d = (load_val > MAX) ? MAX : load_val;
      ovf_d = 1'b0;
    end else if (step) begin
      if (up_dn == DIR_UP) begin
        if (out_q == MAX) begin
`ifdef MOD_COUNTER_SAT_EN
          ovf_d = 1'b1;
`else
          out_d = '0;
          tc_d  = 1'b1;
          ovf_d = 1'b1;
`endif
        end else begin
          out_d = out_q + WIDTH'(1);
        end
      end else begin
        if (out_q == '0) begin
`ifdef MOD_COUNTER_SAT_EN
          ovf_d = 1'b1;
`else
          out_d = MAX;
          tc_d  = 1'b1;
          ovf_d = 1'b1;
`endif
        end else begin
          out_d = out_q - WIDTH'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_q <= '0;
      tc_q  <= 1'b0;
      ovf_q <= 1'b0;
    end else begin
      out_q <= out_d;
      tc_q  <= tc_d;
      ovf_q <= ovf_d;
    end
  end

  assign out = out_q;
  assign tc  = tc_q;
  assign ovf = ovf_q;

endmodule

// File: tb/tb_mod_counter.sv
// tb/tb_mod_counter.sv - scoreboard testbench for mod_counter
// Purpose: drives directed and random stimulus, predicts the count with a
//          behavioural model, and checks out/tc/ovf after every clock edge.
// Configuration: honours MOD_COUNTER_SAT_EN in the reference model.
// Ports: none (top-level bench).
module tb_mod_counter;

  localparam int WIDTH    = 8;
  localparam int MAX_VAL  = 9;
  localparam int PRESCALE = 4;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             en = 1'b0;
  logic             up_dn = 1'b1;
  logic             clr = 1'b0;
  logic             load = 1'b0;
  logic [WIDTH-1:0] load_val = '0;
  logic [WIDTH-1:0] out;
  logic             tc;
  logic             ovf;

  mod_counter #(
    .WIDTH   (WIDTH),
    .MAX_VAL (MAX_VAL),
    .PRESCALE(PRESCALE)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .en      (en),
    .up_dn   (up_dn),
    .clr     (clr),
    .load    (load),
    .load_val(load_val),
    .out     (out),
    .tc      (tc),
    .ovf     (ovf)
  );

  always #5 clk = ~clk;

  typedef struct {
    int cnt;
    bit tc;
    bit ovf;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  // Reference model state
  int m_cnt  = 0;
  int m_phase = 0;
  bit m_ovf  = 0;
  bit m_tc   = 0;

  function automatic void check(string name, int act, int req);
    n_checks++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: actual=%0d required=%0d at %0t", name, act, req, $time);
    end
  endfunction

  function automatic void model_reset();
    m_cnt = 0; m_phase = 0; m_ovf = 0; m_tc = 0;
  endfunction

  function automatic void model_edge(bit e, bit u, bit c, bit l, int lv);
    m_tc = 0;
    if (c) begin
      m_cnt = 0; m_ovf = 0; m_phase = 0;
    end else if (l) begin
      m_cnt = (lv > MAX_VAL) ? MAX_VAL : lv;
      m_ovf = 0; m_phase = 0;
    end else if (e) begin
      m_phase = m_phase + 1;
      if (m_phase == PRESCALE) begin
        m_phase = 0;
        if ((u && m_cnt == MAX_VAL) || (!u && m_cnt == 0)) begin
          m_ovf = 1;
`ifndef MOD_COUNTER_SAT_EN
          m_tc  = 1;
          m_cnt = u ? 0 : MAX_VAL;
`endif
        end else begin
          m_cnt = (m_cnt + (u ? 1 : MAX_VAL)) % (MAX_VAL + 1);
        end
      end
    end
  endfunction

  task automatic drive(bit e, bit u, bit c, bit l, int lv);
    @(negedge clk);
    rst = 1'b1; en = e; up_dn = u; clr = c; load = l; load_val = WIDTH'(lv);
    model_edge(e, u, c, l, lv);
    exp_q.push_back('{cnt: m_cnt, tc: m_tc, ovf: m_ovf});
  endtask

  // Async reset mid-cycle: outputs must drop before any clock edge.
  task automatic async_reset();
    @(negedge clk);
    #2;
    rst = 1'b0; en = 1'b0; clr = 1'b0; load = 1'b0;
    #1;
    check("async_rst_out", int'(out), 0);
    check("async_rst_tc", int'(tc), 0);
    check("async_rst_ovf", int'(ovf), 0);
    model_reset();
    exp_q.push_back('{cnt: 0, tc: 1'b0, ovf: 1'b0});
  endtask

  // Monitor: every edge has one expected result queued by the driver.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("out", int'(out), e.cnt);
        check("tc", int'(tc), int'(e.tc));
        check("ovf", int'(ovf), int'(e.ovf));
      end
    end
  end

  initial begin
    int wait_cycles;
    #1 rst = 1'b0;
    #2;
    check("reset_out", int'(out), 0);
    check("reset_tc", int'(tc), 0);
    check("reset_ovf", int'(ovf), 0);
    model_reset();

    // Count up through a full wrap: 0..9 then 0 with tc and ovf
    for (int i = 0; i < 11 * PRESCALE; i++) drive(1, 1, 0, 0, 0);
    // Freeze with en=0
    for (int i = 0; i < 6; i++) drive(0, 1, 0, 0, 0);
    // Down from 2 across zero to MAX_VAL, then clear
    drive(0, 0, 0, 1, 2);
    for (int i = 0; i < 3 * PRESCALE; i++) drive(1, 0, 0, 0, 0);
    drive(0, 0, 1, 0, 0);
    // Load clamp and clr-over-load priority
    drive(0, 1, 0, 1, 200);
    drive(1, 1, 1, 1, 5);
    // Prescaler phase cleared by load: partial phase then load then full steps
    drive(1, 1, 0, 0, 0);
    drive(1, 1, 0, 0, 0);
    drive(1, 1, 0, 1, 8);
    for (int i = 0; i < 3 * PRESCALE; i++) drive(1, 1, 0, 0, 0);
    // Mid-count reset from 5
    drive(0, 1, 0, 1, 5);
    drive(1, 1, 0, 0, 0);
    async_reset();
    for (int i = 0; i < 2 * PRESCALE; i++) drive(1, 1, 0, 0, 0);

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      if (i % 700 == 350) async_reset();
      else drive($urandom_range(0, 3) != 0, 1'($urandom()),
                 $urandom_range(0, 39) == 0, $urandom_range(0, 29) == 0,
                 int'($urandom_range(0, 255)));
    end

    wait_cycles = 0;
    while (exp_q.size() > 0 && wait_cycles < 20) begin
      @(posedge clk);
      wait_cycles++;
    end
    #2;
    check("scoreboard_drained", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
